// File: rtl/serial_frame_sink.sv
// serial_frame_sink
// Receive-side stage for a bit-serial stream offered under a ready/data
// handshake. Frames are start(1), WIDTH payload bits LSB first, stop(0).
// Good words are buffered in a show-ahead FIFO that feeds a parallel
// valid/ready consumer. A bad stop bit drops the word, pulses frame_err and
// bumps a saturating error counter. ready is withheld whenever the FIFO is
// full, so a stop bit is never accepted without room to store its word.
module serial_frame_sink #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   output logic             ready,
   input  logic             data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic             frame_err,
   output logic [7:0]       err_cnt
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
   localparam logic [CW-1:0] CNT_ZERO_C = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE_C  = CW'(1);
   localparam logic [PW-1:0] PTR_ONE_C  = PW'(1);
   localparam logic [BW-1:0] BIT_ZERO_C = {BW{1'b0}};
   localparam logic [BW-1:0] BIT_ONE_C  = BW'(1);
   localparam logic [BW-1:0] LAST_BIT_C = BW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_STOP  = 2'd2
   } state_t;

   // Frame assembly state
   state_t           state_q,   state_d;
   logic [WIDTH-1:0] shift_q,   shift_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;

   // FIFO state
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q,  wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q,  rd_ptr_d;
   logic [CW-1:0]    count_q,   count_d;

   // Registered outputs
   logic             ready_q,     ready_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic             frame_err_q, frame_err_d;
   logic [7:0]       err_cnt_q,   err_cnt_d;

   // Per-edge events
   logic accept_s;
   logic push_s;
   logic pop_s;
   logic bad_stop_s;

   assign accept_s = ready_q;
   assign pop_s    = out_valid_q & out_ready;

   // Frame FSM: start detection, payload shifting and stop-bit check
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      push_s     = 1'b0;
      bad_stop_s = 1'b0;
      if (accept_s) begin
         case (state_q)
            ST_IDLE: begin
               if (data) begin
                  shift_d   = {WIDTH{1'b0}};
                  bit_cnt_d = BIT_ZERO_C;
                  state_d   = ST_SHIFT;
               end else begin
                  state_d   = ST_IDLE;
               end
            end
            ST_SHIFT: begin
               // Payload arrives LSB first, so each bit enters at the top
               shift_d   = {data, shift_q[WIDTH-1:1]};
               bit_cnt_d = bit_cnt_q + BIT_ONE_C;
               if (bit_cnt_q == LAST_BIT_C) begin
                  state_d = ST_STOP;
               end else begin
                  state_d = ST_SHIFT;
               end
            end
            ST_STOP: begin
               // A 1 here is a framing error, not the start of a new frame
               if (data) begin
                  bad_stop_s = 1'b1;
               end else begin
                  push_s     = 1'b1;
               end
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // FIFO pointers, occupancy and next values of the registered outputs
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE_C;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE_C;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNT_ONE_C;
         2'b01:   count_d = count_q - CNT_ONE_C;
         default: count_d = count_q;
      endcase

      ready_d     = (count_d < DEPTH_C);
      out_valid_d = (count_d != CNT_ZERO_C);

      // The head after this edge is the word being pushed only when it
      // lands exactly at the new read pointer (FIFO empty after any pop)
      if (push_s && (wr_ptr_q == rd_ptr_d)) begin
         out_data_d = shift_q;
      end else if (count_d != CNT_ZERO_C) begin
         out_data_d = mem_q[rd_ptr_d];
      end else begin
         out_data_d = out_data_q;
      end

      frame_err_d = bad_stop_s;
      if (bad_stop_s && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end else begin
         err_cnt_d = err_cnt_q;
      end
   end

   // State and output registers with asynchronous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         shift_q     <= {WIDTH{1'b0}};
         bit_cnt_q   <= BIT_ZERO_C;
         wr_ptr_q    <= {PW{1'b0}};
         rd_ptr_q    <= {PW{1'b0}};
         count_q     <= CNT_ZERO_C;
         ready_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= {WIDTH{1'b0}};
         frame_err_q <= 1'b0;
         err_cnt_q   <= 8'd0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         ready_q     <= ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         frame_err_q <= frame_err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   // FIFO storage; contents need no reset because occupancy gates them
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= shift_q;
      end
   end

   assign ready     = ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign frame_err = frame_err_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_serial_frame_sink.sv
// Directed self-checking bench for serial_frame_sink (WIDTH=8, DEPTH=4).
// Inputs are driven and outputs sampled on the falling edge of clk.
module tb_serial_frame_sink;

   logic       clk;
   logic       rst;
   logic       ready;
   logic       data;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready;
   logic       frame_err;
   logic [7:0] err_cnt;

   int checks = 0;
   int errors = 0;

   serial_frame_sink #(.WIDTH(8), .DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .ready     (ready),
      .data      (data),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .frame_err (frame_err),
      .err_cnt   (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Overall time limit so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
      end
   endtask

   // Present one bit when ready is high; returns at the falling edge after acceptance
   task automatic send_bit(input logic b);
      int guard;
      guard = 0;
      while (!ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!ready) begin
         check_eq("ready_timeout", 32'(ready), 32'd1);
      end
      data = b;
      @(negedge clk);
   endtask

   task automatic send_payload(input logic [7:0] w, input logic stop);
      for (int i = 0; i < 8; i++) begin
         send_bit(w[i]);
      end
      send_bit(stop);
      data = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] w, input logic stop);
      send_bit(1'b1);
      send_payload(w, stop);
   endtask

   // Check the head word, then pop it with a single-cycle out_ready
   task automatic pop_expect(input string tag, input logic [7:0] w);
      check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
      check_eq({tag, "_data"}, 32'(out_data), 32'(w));
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      data      = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);

      // 1. reset values, then idle line
      check_eq("rst_ready", 32'(ready), 32'd0);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_out_data", 32'(out_data), 32'h00);
      check_eq("rst_frame_err", 32'(frame_err), 32'd0);
      check_eq("rst_err_cnt", 32'(err_cnt), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check_eq("ready_after_rst", 32'(ready), 32'd1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check_eq("idle_out_valid", 32'(out_valid), 32'd0);
      end

      // 2. single frame 0xA5 with consumer ready
      out_ready = 1'b1;
      send_frame(8'hA5, 1'b0);
      check_eq("a5_valid", 32'(out_valid), 32'd1);
      check_eq("a5_data", 32'(out_data), 32'hA5);
      check_eq("a5_frame_err", 32'(frame_err), 32'd0);
      @(negedge clk);
      check_eq("a5_popped", 32'(out_valid), 32'd0);
      check_eq("a5_err_cnt", 32'(err_cnt), 32'd0);

      // 3. fill FIFO, stall a fifth frame, drain in order
      out_ready = 1'b0;
      send_frame(8'h01, 1'b0);
      check_eq("fill1_ready", 32'(ready), 32'd1);
      send_frame(8'h02, 1'b0);
      send_frame(8'h03, 1'b0);
      check_eq("fill3_ready", 32'(ready), 32'd1);
      send_frame(8'h04, 1'b0);
      check_eq("full_ready", 32'(ready), 32'd0);
      data = 1'b1;
      repeat (5) @(negedge clk);
      check_eq("stall_ready", 32'(ready), 32'd0);
      check_eq("stall_head", 32'(out_data), 32'h01);
      pop_expect("pop01", 8'h01);
      check_eq("ready_after_pop", 32'(ready), 32'd1);
      check_eq("head_after_pop", 32'(out_data), 32'h02);
      send_bit(1'b1);
      send_payload(8'h06, 1'b0);
      check_eq("refull_ready", 32'(ready), 32'd0);
      pop_expect("pop02", 8'h02);
      pop_expect("pop03", 8'h03);
      pop_expect("pop04", 8'h04);
      pop_expect("pop06", 8'h06);
      check_eq("drained_valid", 32'(out_valid), 32'd0);

      // 4. bad stop bit, then a good frame
      out_ready = 1'b1;
      send_frame(8'h3C, 1'b1);
      check_eq("bad_frame_err", 32'(frame_err), 32'd1);
      check_eq("bad_err_cnt", 32'(err_cnt), 32'd1);
      check_eq("bad_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      check_eq("bad_pulse_end", 32'(frame_err), 32'd0);
      check_eq("bad_valid2", 32'(out_valid), 32'd0);
      out_ready = 1'b0;
      send_frame(8'h5A, 1'b0);
      check_eq("5a_frame_err", 32'(frame_err), 32'd0);
      pop_expect("pop5a", 8'h5A);

      // 5. error counter saturation
      for (int i = 0; i < 253; i++) begin
         send_frame(8'h00, 1'b1);
      end
      check_eq("err_cnt_254", 32'(err_cnt), 32'd254);
      send_frame(8'h00, 1'b1);
      check_eq("err_cnt_255", 32'(err_cnt), 32'd255);
      for (int i = 0; i < 2; i++) begin
         send_frame(8'h00, 1'b1);
      end
      check_eq("err_cnt_sat", 32'(err_cnt), 32'd255);
      check_eq("sat_valid", 32'(out_valid), 32'd0);

      // 6. asynchronous reset mid-frame with two words buffered
      send_frame(8'h11, 1'b0);
      send_frame(8'h22, 1'b0);
      check_eq("pre_rst_head", 32'(out_data), 32'h11);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      rst = 1'b1;
      #1;
      check_eq("async_rst_valid", 32'(out_valid), 32'd0);
      check_eq("async_rst_ready", 32'(ready), 32'd0);
      check_eq("async_rst_err_cnt", 32'(err_cnt), 32'd0);
      data = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rst_hold_ready", 32'(ready), 32'd0);
      check_eq("rst_hold_valid", 32'(out_valid), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check_eq("rerelease_ready", 32'(ready), 32'd1);
      check_eq("rerelease_valid", 32'(out_valid), 32'd0);
      send_frame(8'h81, 1'b0);
      pop_expect("pop81", 8'h81);
      check_eq("post_rst_empty", 32'(out_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
